compute_unit_pbf: RTL and testbench

COMPUTE_UNIT_PBF -- requirements
Module: compute_unit_pbf

---
 rtl/compute_unit_pbf.sv | 269 ++++++++++++++++++++++++++
 tb/tb_compute_unit_pbf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_unit_pbf.sv
// Modular butterfly unit: input FIFO, 3-stage CT/GS/pointwise core, output FIFO.
// Issue is throttled so every in-flight result is guaranteed a slot in the output FIFO.
module compute_unit_pbf #(
    parameter int DW    = 12,
    parameter int Q     = 3329,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] idat1,
    input  logic [DW-1:0] idat2,
    input  logic [DW-1:0] itw,
    input  logic [1:0]    imode,
    input  logic          idatwr,
    output logic          inrdy,
    output logic [DW-1:0] odat1,
    output logic [DW-1:0] odat2,
    input  logic          odatrd,
    output logic          outrdy,
    output logic          busy,
    output logic          ovf,
    output logic          udf
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int OW  = CW + 1;
    localparam int IW  = 3 * DW + 2;
    localparam int XW  = DW + 1;
    localparam int PDW = 2 * DW;

    localparam logic [DW-1:0]  QD       = DW'(Q);
    localparam logic [XW-1:0]  QX       = XW'(Q);
    localparam logic [PDW-1:0] QP       = PDW'(Q);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [OW-1:0]  DEPTH_O  = OW'(DEPTH);

    localparam logic [1:0] MODE_CT  = 2'd0;
    localparam logic [1:0] MODE_GS  = 2'd1;
    localparam logic [1:0] MODE_PW  = 2'd2;
    localparam logic [1:0] MODE_BYP = 2'd3;

    logic [IW-1:0]   r_in_mem [DEPTH];
    logic [PW-1:0]   r_in_wp;
    logic [PW-1:0]   r_in_rp;
    logic [CW-1:0]   r_in_cnt;
    logic            r_rdy_en;

    logic            r_s1_v;
    logic [DW-1:0]   r_s1_a;
    logic [DW-1:0]   r_s1_b;
    logic [DW-1:0]   r_s1_w;
    logic [1:0]      r_s1_mode;

    logic            r_s2_v;
    logic [DW-1:0]   r_s2_a;
    logic [DW-1:0]   r_s2_b;
    logic [PDW-1:0]  r_s2_prod;
    logic [1:0]      r_s2_mode;

    logic            r_s3_v;
    logic [DW-1:0]   r_s3_o1;
    logic [DW-1:0]   r_s3_o2;

    logic [PDW-1:0]  r_out_mem [DEPTH];
    logic [PW-1:0]   r_out_wp;
    logic [PW-1:0]   r_out_rp;
    logic [CW-1:0]   r_out_cnt;

    logic            r_ovf;
    logic            r_udf;

    logic            w_in_wr;
    logic            w_pop;
    logic            w_issue;
    logic [OW-1:0]   w_occ;
    logic [IW-1:0]   w_head;
    logic [PDW-1:0]  w_out_head;
    logic [DW-1:0]   w_diff;
    logic [PDW-1:0]  w_prod;
    logic [DW-1:0]   w_t;
    logic [XW-1:0]   w_sum;
    logic [DW-1:0]   w_o1_add;
    logic [DW-1:0]   w_sub;
    logic [DW-1:0]   w_o1;
    logic [DW-1:0]   w_o2;

    assign inrdy   = r_rdy_en && (r_in_cnt != FULL_CNT);
    assign outrdy  = (r_out_cnt != {CW{1'b0}});
    assign w_in_wr = idatwr && inrdy;
    assign w_pop   = odatrd && outrdy;
    // A pop on this edge frees a slot, so it is credited before the issue decision.
    assign w_occ   = OW'(r_out_cnt) + OW'(r_s1_v) + OW'(r_s2_v) + OW'(r_s3_v) - OW'(w_pop);
    assign w_issue = (r_in_cnt != {CW{1'b0}}) && (w_occ < DEPTH_O);
    assign w_head  = r_in_mem[r_in_rp];

    assign w_out_head = r_out_mem[r_out_rp];
    assign odat1      = outrdy ? w_out_head[DW-1:0]   : {DW{1'b0}};
    assign odat2      = outrdy ? w_out_head[PDW-1:DW] : {DW{1'b0}};
    assign busy       = (r_in_cnt != {CW{1'b0}}) || r_s1_v || r_s2_v || r_s3_v || outrdy;
    assign ovf        = r_ovf;
    assign udf        = r_udf;

    // Input FIFO storage.
    always_ff @(posedge clk) begin
        if (w_in_wr) begin
            r_in_mem[r_in_wp] <= {imode, itw, idat2, idat1};
        end
    end

    // Input FIFO pointers, occupancy and post-reset ready enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_wp  <= {PW{1'b0}};
            r_in_rp  <= {PW{1'b0}};
            r_in_cnt <= {CW{1'b0}};
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_in_wr) begin
                r_in_wp <= r_in_wp + PW'(1'b1);
            end
            if (w_issue) begin
                r_in_rp <= r_in_rp + PW'(1'b1);
            end
            r_in_cnt <= r_in_cnt + CW'(w_in_wr) - CW'(w_issue);
        end
    end

    // Stage 1: capture the issued tuple.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v    <= 1'b0;
            r_s1_a    <= {DW{1'b0}};
            r_s1_b    <= {DW{1'b0}};
            r_s1_w    <= {DW{1'b0}};
            r_s1_mode <= MODE_CT;
        end else begin
            r_s1_v <= w_issue;
            if (w_issue) begin
                {r_s1_mode, r_s1_w, r_s1_b, r_s1_a} <= w_head;
            end
        end
    end

    // Stage 2 datapath: full-width product per mode; a-b+Q wraps correctly in DW bits.
    always_comb begin
        w_diff = {DW{1'b0}};
        w_prod = {PDW{1'b0}};
        if (r_s1_a >= r_s1_b) begin
            w_diff = r_s1_a - r_s1_b;
        end else begin
            w_diff = r_s1_a - r_s1_b + QD;
        end
        case (r_s1_mode)
            MODE_CT: w_prod = PDW'(r_s1_b) * PDW'(r_s1_w);
            MODE_GS: w_prod = PDW'(w_diff) * PDW'(r_s1_w);
            MODE_PW: w_prod = PDW'(r_s1_a) * PDW'(r_s1_b);
            default: w_prod = {PDW{1'b0}};
        endcase
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_v    <= 1'b0;
            r_s2_a    <= {DW{1'b0}};
            r_s2_b    <= {DW{1'b0}};
            r_s2_prod <= {PDW{1'b0}};
            r_s2_mode <= MODE_CT;
        end else begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_a    <= r_s1_a;
                r_s2_b    <= r_s1_b;
                r_s2_prod <= w_prod;
                r_s2_mode <= r_s1_mode;
            end
        end
    end

    // Stage 3 datapath: exact reduction of the product, then modular add/subtract.
    always_comb begin
        w_t   = DW'(r_s2_prod % QP);
        w_sum = {1'b0, r_s2_a} + {1'b0, ((r_s2_mode == MODE_GS) ? r_s2_b : w_t)};
        if (w_sum >= QX) begin
            w_o1_add = DW'(w_sum - QX);
        end else begin
            w_o1_add = w_sum[DW-1:0];
        end
        if (r_s2_a >= w_t) begin
            w_sub = r_s2_a - w_t;
        end else begin
            w_sub = r_s2_a - w_t + QD;
        end
        case (r_s2_mode)
            MODE_CT: begin
                w_o1 = w_o1_add;
                w_o2 = w_sub;
            end
            MODE_GS: begin
                w_o1 = w_o1_add;
                w_o2 = w_t;
            end
            MODE_PW: begin
                w_o1 = w_t;
                w_o2 = {DW{1'b0}};
            end
            default: begin
                w_o1 = r_s2_a;
                w_o2 = r_s2_b;
            end
        endcase
    end

    // Stage 3 register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s3_v  <= 1'b0;
            r_s3_o1 <= {DW{1'b0}};
            r_s3_o2 <= {DW{1'b0}};
        end else begin
            r_s3_v <= r_s2_v;
            if (r_s2_v) begin
                r_s3_o1 <= w_o1;
                r_s3_o2 <= w_o2;
            end
        end
    end

    // Output FIFO storage; stage 3 retires straight into it.
    always_ff @(posedge clk) begin
        if (r_s3_v) begin
            r_out_mem[r_out_wp] <= {r_s3_o2, r_s3_o1};
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_wp  <= {PW{1'b0}};
            r_out_rp  <= {PW{1'b0}};
            r_out_cnt <= {CW{1'b0}};
        end else begin
            if (r_s3_v) begin
                r_out_wp <= r_out_wp + PW'(1'b1);
            end
            if (w_pop) begin
                r_out_rp <= r_out_rp + PW'(1'b1);
            end
            r_out_cnt <= r_out_cnt + CW'(r_s3_v) - CW'(w_pop);
        end
    end

    // Sticky overflow / underflow flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (idatwr && !inrdy) begin
                r_ovf <= 1'b1;
            end
            if (odatrd && !outrdy) begin
                r_udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_compute_unit_pbf.sv
// Directed bench for compute_unit_pbf: reset, latency, per-mode vectors, back-pressure,
// underflow, random streaming against a formula model, and mid-operation reset.
module tb_compute_unit_pbf;
    localparam int DW    = 12;
    localparam int Q     = 3329;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] idat1 = '0;
    logic [DW-1:0] idat2 = '0;
    logic [DW-1:0] itw = '0;
    logic [1:0]    imode = '0;
    logic          idatwr = 1'b0;
    logic          odatrd = 1'b0;
    logic          inrdy, outrdy, busy, ovf, udf;
    logic [DW-1:0] odat1, odat2;
    logic [4:0]    flags;

    int total = 0;
    int bad   = 0;
    int q1[$];
    int q2[$];
    int got   = 0;
    int gaps  = 0;
    int notrdy = 0;
    bit started = 1'b0;

    compute_unit_pbf #(.DW(DW), .Q(Q), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .idat1(idat1), .idat2(idat2), .itw(itw), .imode(imode),
        .idatwr(idatwr), .inrdy(inrdy),
        .odat1(odat1), .odat2(odat2), .odatrd(odatrd), .outrdy(outrdy),
        .busy(busy), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    assign flags = {inrdy, outrdy, busy, ovf, udf};

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int a, input int b, input int w, input int m);
        idat1 = a[DW-1:0];
        idat2 = b[DW-1:0];
        itw   = w[DW-1:0];
        imode = m[1:0];
    endtask

    task automatic wr(input int a, input int b, input int w, input int m);
        drive(a, b, w, m);
        idatwr = 1'b1;
        @(negedge clk);
        idatwr = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int e1, input int e2);
        int n = 0;
        while (outrdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, outrdy, 1);
        chk({tag, "_o1"}, odat1, e1);
        chk({tag, "_o2"}, odat2, e2);
        odatrd = 1'b1;
        @(negedge clk);
        odatrd = 1'b0;
    endtask

    function automatic void ref_model(input int a, input int b, input int w, input int m,
                                      output int o1, output int o2);
        int t;
        case (m)
            0: begin
                t  = (b * w) % Q;
                o1 = (a + t) % Q;
                o2 = (a - t + Q) % Q;
            end
            1: begin
                o1 = (a + b) % Q;
                o2 = (((a - b + Q) % Q) * w) % Q;
            end
            2: begin
                o1 = (a * b) % Q;
                o2 = 0;
            end
            default: begin
                o1 = a;
                o2 = b;
            end
        endcase
    endfunction

    task automatic str_sample();
        int e1, e2;
        if (outrdy === 1'b1) begin
            if (q1.size() == 0) begin
                chk("str_extra", outrdy, 0);
            end else begin
                e1 = q1.pop_front();
                e2 = q2.pop_front();
                chk($sformatf("str%0d_o1", got), odat1, e1);
                chk($sformatf("str%0d_o2", got), odat2, e2);
                got++;
                started = 1'b1;
            end
        end else if (started && q1.size() > 0) begin
            gaps++;
        end
    endtask

    initial begin
        // Reset values
        step(2);
        chk("rst_flags", flags, 5'b00000);
        chk("rst_odat", {odat1, odat2}, 0);
        rst = 1'b1;
        #1;
        chk("rdy_pre_edge", inrdy, 0);
        step(1);
        chk("rdy_rise", flags, 5'b10000);

        // Four-clock latency, mode 0
        wr(5, 3, 17, 0);
        chk("lat_e0", flags, 5'b10100);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk($sformatf("lat_e%0d_outrdy", k), outrdy, 0);
        end
        step(1);
        chk("lat_e4_outrdy", outrdy, 1);
        chk("lat_o1", odat1, 56);
        chk("lat_o2", odat2, 3283);
        odatrd = 1'b1;
        step(1);
        odatrd = 1'b0;
        chk("lat_drained", flags, 5'b10000);

        // Per-mode vectors, consecutive tuples of mixed modes
        wr(1, 2, 3, 1);
        wr(3328, 3328, 55, 2);
        wr(7, 9, 1234, 3);
        wr(3328, 3328, 3328, 0);
        wr(0, 1, 1, 0);
        wr(0, 3328, 3328, 1);
        pop_chk("gs_1_2_3", 3, 3326);
        pop_chk("pw_max", 1, 0);
        pop_chk("byp", 7, 9);
        pop_chk("ct_max", 0, 3327);
        pop_chk("ct_zero", 1, 3328);
        pop_chk("gs_wrap", 3328, 3328);
        step(2);
        chk("modes_idle", flags, 5'b10000);

        // Back-pressure: 2*DEPTH accepted, one dropped
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            chk($sformatf("bp_inrdy%0d", i), inrdy, (i < 2 * DEPTH) ? 1 : 0);
            drive(100 + i, 200 + i, 0, 3);
            idatwr = 1'b1;
            @(negedge clk);
        end
        idatwr = 1'b0;
        chk("bp_full", flags, 5'b01110);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            pop_chk($sformatf("bp_pop%0d", i), 100 + i, 200 + i);
        end
        step(8);
        chk("bp_empty", flags, 5'b10010);

        // Underflow, then exactly one result
        odatrd = 1'b1;
        step(1);
        odatrd = 1'b0;
        chk("udf_set", flags, 5'b10011);
        wr(100, 200, 300, 0);
        pop_chk("udf_one", 178, 22);
        step(8);
        chk("udf_idle", flags, 5'b10011);

        // Streaming: write and pop every cycle
        odatrd = 1'b1;
        for (int i = 0; i < 100; i++) begin
            int a, b, w, m, e1, e2;
            str_sample();
            if (inrdy !== 1'b1) notrdy++;
            a = int'($urandom_range(Q - 1, 0));
            b = int'($urandom_range(Q - 1, 0));
            w = int'($urandom_range(Q - 1, 0));
            m = int'($urandom_range(3, 0));
            ref_model(a, b, w, m, e1, e2);
            q1.push_back(e1);
            q2.push_back(e2);
            drive(a, b, w, m);
            idatwr = 1'b1;
            @(negedge clk);
        end
        idatwr = 1'b0;
        for (int k = 0; k < 20 && q1.size() > 0; k++) begin
            str_sample();
            @(negedge clk);
        end
        odatrd = 1'b0;
        chk("str_count", got, 100);
        chk("str_gaps", gaps, 0);
        chk("str_inrdy_drops", notrdy, 0);

        // Reset with data in the output FIFO and pipeline
        wr(1, 2, 3, 0);
        wr(4, 5, 6, 1);
        wr(7, 8, 9, 2);
        step(2);
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_o1", odat1, 7);
        chk("mid_pre_o2", odat2, 3324);
        rst = 1'b0;
        #1;
        chk("mid_rst_flags", flags, 5'b00000);
        chk("mid_rst_odat", {odat1, odat2}, 0);
        step(2);
        rst = 1'b1;
        step(1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("mid_after%0d", k), flags, 5'b10000);
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
